// File: rtl/logic_unit_serial.sv
// Serial bitwise logic unit: evaluates one of eight logic functions on two
// latched operands SLICE bits per cycle, then loads a flagged result register.
module logic_unit_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             parity,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("logic_unit_serial: WIDTH must be >= 1 and a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       s_q, s_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  int unsigned      base;

  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] op,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
    logic [SLICE-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~a;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = ~(a ^ b);
      default: r = b;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    parity_d = parity_q;
    base     = 32'(cnt_q) * 32'(SLICE);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          s_d     = S;
          work_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d[base +: SLICE] = slice_op(s_q, a_q[base +: SLICE], b_q[base +: SLICE]);
        // Counter parks on the last slice instead of wrapping.
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        out_d    = work_q;
        zero_d   = ~|work_q;
        parity_d = ^work_q;
        if (start) begin
          a_d     = A;
          b_d     = B;
          s_d     = S;
          work_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      zero_q   <= zero_d;
      parity_q <= parity_d;
    end
  end

  assign out    = out_q;
  assign zero   = zero_q;
  assign parity = parity_q;
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);

endmodule

// File: tb/tb_logic_unit_serial.sv
// Bench for logic_unit_serial: three configurations (8/1, 16/4, 8/8) driven
// one at a time; a monitor scores each loaded result against a queue.
module tb_logic_unit_serial;

  typedef struct packed {
    int          dut;
    logic [15:0] o;
    logic        z;
    logic        p;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st    [3];
  logic [15:0] a_v   [3];
  logic [15:0] b_v   [3];
  logic [2:0]  s_v   [3];
  logic [15:0] outv  [3];
  logic        zerov [3];
  logic        parv  [3];
  logic        busyv [3];
  logic        donev [3];
  logic [7:0]  out0, out2;
  logic [15:0] out1;

  int w_a [3] = '{8, 16, 8};
  int n_a [3] = '{8, 4, 1};

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t hold [3];
  logic pend [3];
  int   brun [3];

  always #5 clk = ~clk;

  logic_unit_serial #(.WIDTH(8), .SLICE(1)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .A(a_v[0][7:0]), .B(b_v[0][7:0]), .S(s_v[0]),
    .out(out0), .zero(zerov[0]), .parity(parv[0]), .busy(busyv[0]), .done(donev[0]));
  logic_unit_serial #(.WIDTH(16), .SLICE(4)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .A(a_v[1]), .B(b_v[1]), .S(s_v[1]),
    .out(out1), .zero(zerov[1]), .parity(parv[1]), .busy(busyv[1]), .done(donev[1]));
  logic_unit_serial #(.WIDTH(8), .SLICE(8)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .A(a_v[2][7:0]), .B(b_v[2][7:0]), .S(s_v[2]),
    .out(out2), .zero(zerov[2]), .parity(parv[2]), .busy(busyv[2]), .done(donev[2]));

  assign outv[0] = {8'h00, out0};
  assign outv[1] = out1;
  assign outv[2] = {8'h00, out2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference: whole-word bitwise function, truncated to the configured width.
  function automatic logic [15:0] ref_model(input logic [2:0] s, input logic [15:0] a,
                                            input logic [15:0] b, input int w);
    logic [15:0] r;
    case (s)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: r = ~(a & b);
      3'd5: r = ~(a | b);
      3'd6: r = ~(a ^ b);
      default: r = b;
    endcase
    return (w == 16) ? r : (r & 16'h00FF);
  endfunction

  task automatic push_exp(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    exp_t e;
    e.dut = i;
    e.o   = ref_model(s, a, b, w_a[i]);
    e.z   = (e.o == 16'h0);
    e.p   = ^e.o;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busyv[i] && donev[i]) chk($sformatf("busy_done_overlap%0d", i), 1, 0);
      if (pend[i]) begin
        pend[i] = 1'b0;
        chk($sformatf("out_d%0d", i), 32'(outv[i]), 32'(hold[i].o));
        chk($sformatf("zero_d%0d", i), 32'(zerov[i]), 32'(hold[i].z));
        chk($sformatf("parity_d%0d", i), 32'(parv[i]), 32'(hold[i].p));
      end
      if (rst) begin
        brun[i] = 0;
      end else if (donev[i]) begin
        chk($sformatf("busy_len_d%0d", i), 32'(brun[i]), 32'(n_a[i]));
        brun[i] = 0;
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_done_d%0d", i), 1, 0);
        end else begin
          hold[i] = exp_q.pop_front();
          chk($sformatf("done_dut_order%0d", i), 32'(hold[i].dut), 32'(i));
          pend[i] = 1'b1;
        end
      end else if (busyv[i]) begin
        brun[i]++;
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    @(negedge clk);
    st[i] = 1'b1; a_v[i] = a; b_v[i] = b; s_v[i] = s;
    push_exp(i, a, b, s);
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  // Waits (bounded) until the done cycle of DUT i, leaving time at a negedge.
  task automatic wait_done(input int i);
    int cnt = 0;
    while (!donev[i] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) chk($sformatf("timeout_d%0d", i), 1, 0);
  endtask

  task automatic run_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
    issue(i, a, b, s);
    wait_done(i);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; s_v[i] = '0; pend[i] = 1'b0; brun[i] = 0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_out%0d", i), 32'(outv[i]), 0);
      chk($sformatf("rst_zero%0d", i), 32'(zerov[i]), 1);
      chk($sformatf("rst_parity%0d", i), 32'(parv[i]), 0);
      chk($sformatf("rst_busy%0d", i), 32'(busyv[i]), 0);
      chk($sformatf("rst_done%0d", i), 32'(donev[i]), 0);
    end
    rst = 1'b0;

    // Opcode sweep on each configuration.
    for (int s = 0; s < 8; s++) run_op(0, 16'h00F0, 16'h003C, 3'(s));
    for (int s = 0; s < 8; s++) run_op(1, 16'h5AF0, 16'h3C3C, 3'(s));
    for (int s = 0; s < 8; s++) run_op(2, 16'h00F0, 16'h003C, 3'(s));

    // Zero-result cases.
    run_op(0, 16'h00AA, 16'h00AA, 3'b010);
    run_op(0, 16'h00FF, 16'h0000, 3'b101);

    // start and operands toggled throughout RUN must not disturb the op.
    issue(0, 16'h000F, 16'h00FF, 3'b000);
    for (int c = 0; c < 100 && !donev[0]; c++) begin
      if (busyv[0]) begin
        st[0] = 1'($urandom); a_v[0] = 16'($urandom); b_v[0] = 16'($urandom); s_v[0] = 3'($urandom);
      end
      @(negedge clk);
    end
    st[0] = 1'b0;
    wait_done(0);
    repeat (3) @(negedge clk);
    chk("no_extra_op", 32'(busyv[0] | donev[0]), 0);

    // Back-to-back: start held in the done cycle.
    issue(0, 16'h00C3, 16'h0011, 3'b001);
    wait_done(0);
    st[0] = 1'b1; a_v[0] = 16'h0081; b_v[0] = 16'h0000; s_v[0] = 3'b001;
    push_exp(0, 16'h0081, 16'h0000, 3'b001);
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_no_idle", 32'(busyv[0]), 1);
    wait_done(0);
    repeat (2) @(negedge clk);

    // Reset during slice 4 aborts the op.
    issue(0, 16'h00F3, 16'h0000, 3'b001);
    begin
      exp_t drop;
      drop = exp_q.pop_back();
      chk("abort_exp_nonzero", 32'(drop.o), 32'h00F3);
    end
    repeat (4) @(negedge clk);
    chk("abort_in_run", 32'(busyv[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", 32'(outv[0]), 0);
    chk("abort_zero", 32'(zerov[0]), 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (donev[0]) chk("abort_done", 1, 0);
    end
    run_op(0, 16'h0055, 16'h00FF, 3'b110);

    // Randomised operations on every configuration.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 3; i++) begin
        ra = 16'($urandom); rb = 16'($urandom);
        if (w_a[i] == 8) begin ra[15:8] = 8'h00; rb[15:8] = 8'h00; end
        run_op(i, ra, rb, 3'($urandom_range(0, 7)));
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
